fetch_queue: RTL and testbench

Instruction-fetch front end for the 5-stage MIPS pipeline. Sits between a multi-cycle instruction memory (req/ack handshake) and the IF/ID pipeline register.
- Keeps a fetch PC and issues at most one outstanding memory request.
- Buffers returned words in a small FIFO, tagged with PC+4, so fetch continues during IF/ID stalls.
- On a branch/jump redirect from the EX stage, discards all buffered and in-flight words.

---
 rtl/fetch_queue_pkg.sv | 22 ++
 rtl/fetch_queue_if.sv | 10 +
 rtl/fetch_queue_fifo.sv | 44 ++++
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory req/ack handshake between fetch_queue (master) and memory (slave).
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO with clear; pointers wrap modulo DEPTH, full/empty come from count.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clear && push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: one outstanding imem request, word FIFO tagged with PC+4, redirect flush.
// Optional zero-latency bypass of an ack into an empty queue: define FETCH_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  fetch_queue_if.master    imem,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             stall,
  output logic             valid,
  output logic [31:0]      instr,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         fifo_empty, ack_ok, bypass, push, pop;
  logic [CNT_W-1:0] count_after;
  fetch_entry_t fifo_din, head;

  assign fifo_empty = (count == '0);
  assign ack_ok     = (state_q == REQ) && imem.imem_ack;

`ifdef FETCH_BYPASS_EN
  assign bypass = ack_ok && fifo_empty && !redirect && !stall;
`else
  assign bypass = 1'b0;
`endif

  assign push        = ack_ok && !redirect && !bypass;
  assign pop         = !fifo_empty && !stall && !redirect;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);
  assign fifo_din    = '{instr: imem.imem_rdata, pc_plus4: fetch_pc_q + 32'd4};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t)),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // DRAIN keeps presenting the abandoned address while fetch_pc already holds the redirect target.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    drain_addr_d   = drain_addr_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (!redirect && (count < DEPTH_C)) state_d = REQ;
      end
      REQ: begin
        imem.imem_req = 1'b1;
        if (redirect) begin
          drain_addr_d = fetch_pc_q;
          state_d      = imem.imem_ack ? IDLE : DRAIN;
        end else if (imem.imem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_after < DEPTH_C) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = drain_addr_q;
        if (imem.imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) fetch_pc_d = word_align(redirect_pc);
  end

  always_comb begin
    valid    = !fifo_empty;
    instr    = head.instr;
    pc_plus4 = head.pc_plus4;
    if (bypass) begin
      valid    = 1'b1;
      instr    = imem.imem_rdata;
      pc_plus4 = fetch_pc_q + 32'd4;
    end else if (fifo_empty) begin
      instr    = NOP_INSTR;
      pc_plus4 = '0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue with a request/epoch-based reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  typedef struct {
    int cycles;
    int stall_pct;
    int ack_pct;
    int redir_pct;
  } phase_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic [2:0]  count;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .valid       (valid),
    .instr       (instr),
    .pc_plus4    (pc_plus4),
    .count       (count)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetched words in order; a request is stale if a redirect or reset came after it was issued.
  ent_t        q[$];
  logic [31:0] exp_pc    = RPC;
  logic [31:0] req_addr  = '0;
  int          epoch     = 0;
  int          req_epoch = 0;
  bit          busy      = 0;
  bit          live      = 0;
  bit          after_rst = 0;
  int          pops      = 0;

  always @(negedge clk) begin
    bit fresh_ack;
    bit exp_bypass;
    bit exp_valid;
    if (!rst) begin
      if (live && after_rst) check("req_in_reset", 32'(bus.imem_req), 32'd0);
      q.delete();
      busy      = 0;
      epoch++;
      exp_pc    = RPC;
      after_rst = 1;
      live      = 1;
    end else if (live) begin
      if (after_rst) check("req_after_reset", 32'(bus.imem_req), 32'd0);
      after_rst = 0;

      if (busy) begin
        check("req_held", 32'(bus.imem_req), 32'd1);
        check("addr_stable", bus.imem_addr, req_addr);
      end else if (bus.imem_req) begin
        busy      = 1;
        req_epoch = epoch;
        req_addr  = bus.imem_addr;
        check("fetch_addr", bus.imem_addr, exp_pc);
      end

      fresh_ack = bus.imem_req && bus.imem_ack && (req_epoch == epoch);
`ifdef FETCH_BYPASS_EN
      exp_bypass = fresh_ack && !redirect && !stall && (q.size() == 0);
`else
      exp_bypass = 0;
`endif
      exp_valid = (q.size() != 0) || exp_bypass;

      check("count", 32'(count), 32'(q.size()));
      check("valid", 32'(valid), 32'(exp_valid));
      if (q.size() == DEPTH) check("full_no_req", 32'(bus.imem_req), 32'd0);
      if (exp_bypass) begin
        check("bypass_instr", instr, bus.imem_rdata);
        check("bypass_pc4", pc_plus4, req_addr + 32'd4);
      end else if (q.size() != 0) begin
        check("head_instr", instr, q[0].instr);
        check("head_pc4", pc_plus4, q[0].pc4);
      end else begin
        check("nop_instr", instr, NOP_INSTR);
        check("nop_pc4", pc_plus4, 32'd0);
      end

      if (q.size() != 0 && !stall && !redirect) begin
        void'(q.pop_front());
        pops++;
      end
      if (bus.imem_req && bus.imem_ack) begin
        busy = 0;
        if (fresh_ack && !redirect) begin
          if (exp_bypass) pops++;
          else q.push_back('{instr: bus.imem_rdata, pc4: req_addr + 32'd4});
          exp_pc = req_addr + 32'd4;
        end
      end
      if (redirect) begin
        q.delete();
        epoch++;
        exp_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  task automatic drive(input phase_t p);
    stall          = ($urandom_range(0, 99) < p.stall_pct);
    redirect       = ($urandom_range(0, 99) < p.redir_pct);
    redirect_pc    = 32'($urandom_range(0, 4095));
    bus.imem_ack   = bus.imem_req && ($urandom_range(0, 99) < p.ack_pct);
    bus.imem_rdata = $urandom;
  endtask

  phase_t phases[6];

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    phases[0] = '{cycles: 150, stall_pct: 0,   ack_pct: 100, redir_pct: 0};
    phases[1] = '{cycles: 40,  stall_pct: 100, ack_pct: 100, redir_pct: 0};
    phases[2] = '{cycles: 60,  stall_pct: 0,   ack_pct: 100, redir_pct: 0};
    phases[3] = '{cycles: 500, stall_pct: 30,  ack_pct: 40,  redir_pct: 6};
    phases[4] = '{cycles: 400, stall_pct: 60,  ack_pct: 25,  redir_pct: 12};
    phases[5] = '{cycles: 300, stall_pct: 10,  ack_pct: 90,  redir_pct: 20};

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    foreach (phases[k]) begin
      for (int c = 0; c < phases[k].cycles; c++) begin
        @(posedge clk);
        #1 drive(phases[k]);
      end
    end

    // Mid-request reset with a partly filled queue.
    begin
      phase_t fill;
      bit hit;
      fill = '{cycles: 0, stall_pct: 100, ack_pct: 50, redir_pct: 0};
      hit  = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
        @(posedge clk);
        #1;
        if (bus.imem_req && count >= 3'd2) hit = 1;
        else drive(fill);
      end
      compared++;
      if (!hit) begin
        mismatched++;
        $display("FAIL reset_setup: got no request with count>=2 expected one within 200 cycles");
      end
      bus.imem_ack = 1'b0;
      redirect     = 1'b0;
      rst          = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
    end

    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1 drive(phases[3]);
    end
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    redirect     = 1'b0;
    @(negedge clk);

    compared++;
    if (pops < 100) begin
      mismatched++;
      $display("FAIL progress: got %0d words delivered expected at least 100", pops);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
